// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C command sequencer: controller register
// map, CR command bytes, SR bit positions, response codes and FSM states.
package i2c_seq_pkg;

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    localparam logic [7:0] CTR_EN           = 8'h80;
    localparam logic [7:0] CMD_START_WR     = 8'h90;
    localparam logic [7:0] CMD_WR           = 8'h10;
    localparam logic [7:0] CMD_WR_STOP      = 8'h50;
    localparam logic [7:0] CMD_RD_NACK_STOP = 8'h68;
    localparam logic [7:0] CMD_STOP         = 8'h40;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_AL      = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_POLL,
        ST_CHECK,
        ST_STOP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response handshake plus the WISHBONE master bus toward the I2C controller.
interface i2c_cmd_sequencer_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_rw_i;
    logic [6:0] cmd_dev_i;
    logic [7:0] cmd_reg_i;
    logic [7:0] cmd_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic [1:0] rsp_err_o;
    logic       m_cyc_o;
    logic       m_stb_o;
    logic       m_we_o;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_ack_i;

    modport master (
        input  cmd_valid_i, cmd_rw_i, cmd_dev_i, cmd_reg_i, cmd_wdata_i, m_dat_i, m_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_rw_i, cmd_dev_i, cmd_reg_i, cmd_wdata_i, m_dat_i, m_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
    );
endinterface

// File: rtl/i2c_seq_wb_access.sv
// Single-access WISHBONE master: launches one read or write, holds it until ack,
// then pulses done with the captured read data.
module i2c_seq_wb_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] dat,
    output logic       done,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       m_cyc_o,
    output logic       m_stb_o,
    output logic       m_we_o,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    input  logic       m_ack_i
);
    logic       cyc_q, cyc_d, we_q, we_d, done_q, done_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d, rdata_q, rdata_d;

    // Blocking new starts during the done cycle guarantees cyc is low between accesses.
    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        if (cyc_q) begin
            if (m_ack_i) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                adr_d   = '0;
                dat_d   = '0;
                rdata_d = m_dat_i;
                done_d  = 1'b1;
            end
        end else if (start && !done_q) begin
            cyc_d = 1'b1;
            we_d  = we;
            adr_d = adr;
            dat_d = dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign busy    = cyc_q | done_q;
    assign rdata   = rdata_q;
    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o  = we_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Turns one register read/write command into the full I2C controller register
// sequence, polling SR per byte and returning one response per command.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE      = 16'd99,
    parameter int          TIMEOUT_POLLS = 4096
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    i2c_cmd_sequencer_if.master bus
);
    localparam int PCW = $clog2(TIMEOUT_POLLS) + 1;

    state_e         state_q, state_d;
    err_e           err_q, err_d;
    logic [2:0]     step_q, step_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic           rw_q, rw_d;
    logic [6:0]     dev_q, dev_d;
    logic [7:0]     reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;

    logic       acc_start, acc_we, acc_done, acc_busy, final_rd;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat, acc_rdata;

    // Steps: even = TXR byte, odd = CR command; read adds step 6 (CR 0x68) and 7 (RXR).
    assign final_rd  = rw_q && (step_q == 3'd6);
    assign acc_start = (state_q inside {ST_INIT, ST_ACCESS, ST_POLL, ST_STOP}) && !acc_busy;

    always_comb begin
        acc_we  = 1'b1;
        acc_adr = ADR_CR;
        acc_dat = CMD_STOP;
        case (state_q)
            ST_INIT: begin
                acc_adr = step_q;
                acc_dat = (step_q == 3'd0) ? PRESCALE[7:0] :
                          (step_q == 3'd1) ? PRESCALE[15:8] : CTR_EN;
            end
            ST_ACCESS: begin
                if (step_q == 3'd7) begin
                    acc_we  = 1'b0;
                    acc_adr = ADR_RXR;
                    acc_dat = '0;
                end else if (step_q == 3'd6) begin
                    acc_dat = CMD_RD_NACK_STOP;
                end else if (step_q[0]) begin
                    acc_dat = (step_q == 3'd1) ? CMD_START_WR :
                              (step_q == 3'd3) ? CMD_WR :
                              (rw_q ? CMD_START_WR : CMD_WR_STOP);
                end else begin
                    acc_adr = ADR_TXR;
                    acc_dat = (step_q == 3'd0) ? {dev_q, 1'b0} :
                              (step_q == 3'd2) ? reg_q :
                              (rw_q ? {dev_q, 1'b1} : wdata_q);
                end
            end
            ST_POLL: begin
                acc_we  = 1'b0;
                acc_adr = ADR_SR;
                acc_dat = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        step_d  = step_q;
        poll_d  = poll_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_INIT: if (acc_done) begin
                step_d = step_q + 3'd1;
                if (step_q == 3'd2) begin
                    step_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: if (bus.cmd_valid_i) begin
                rw_d    = bus.cmd_rw_i;
                dev_d   = bus.cmd_dev_i;
                reg_d   = bus.cmd_reg_i;
                wdata_d = bus.cmd_wdata_i;
                step_d  = '0;
                rdata_d = '0;
                err_d   = ERR_OK;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: if (acc_done) begin
                if (step_q == 3'd7) begin
                    rdata_d = acc_rdata;
                    state_d = ST_RESP;
                end else if (step_q[0] || step_q == 3'd6) begin
                    poll_d  = '0;
                    state_d = ST_POLL;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_POLL: if (acc_done) begin
                if (!acc_rdata[SR_TIP]) begin
                    state_d = ST_CHECK;
                end else if (poll_q == PCW'(TIMEOUT_POLLS - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_STOP;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
            end
            // Arbitration loss means the bus is no longer ours, so no STOP is issued.
            ST_CHECK: begin
                if (acc_rdata[SR_AL]) begin
                    err_d   = ERR_AL;
                    state_d = ST_RESP;
                end else if (acc_rdata[SR_RXACK] && !final_rd) begin
                    err_d   = ERR_NACK;
                    state_d = ST_STOP;
                end else if (!rw_q && step_q == 3'd5) begin
                    state_d = ST_RESP;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = ST_ACCESS;
                end
            end
            ST_STOP: if (acc_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_INIT;
            err_q   <= ERR_OK;
            step_q  <= '0;
            poll_q  <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cmd_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    i2c_seq_wb_access u_acc (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .start   (acc_start),
        .we      (acc_we),
        .adr     (acc_adr),
        .dat     (acc_dat),
        .done    (acc_done),
        .busy    (acc_busy),
        .rdata   (acc_rdata),
        .m_cyc_o (bus.m_cyc_o),
        .m_stb_o (bus.m_stb_o),
        .m_we_o  (bus.m_we_o),
        .m_adr_o (bus.m_adr_o),
        .m_dat_o (bus.m_dat_o),
        .m_dat_i (bus.m_dat_i),
        .m_ack_i (bus.m_ack_i)
    );
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- WISHBONE master that sits directly upstream of the I2C master controller and drives its register interface (PRER, CTR, TXR/RXR, CR/SR).
- Converts one simple command (7-bit device address, 8-bit register address, read/write, write data) into the full register-access sequence: start, address, register, data or repeated-start read, stop.
- Polls SR for completion and returns one response (read data plus error code) per command.
- Programs the prescaler and sets CTR.EN automatically after reset.

Parameters:
- PRESCALE, 16'd99, value written to PRERhi:PRERlo during init (50 MHz clock / (5*100 kHz) - 1).
- TIMEOUT_POLLS, 4096, maximum SR reads per byte before declaring a timeout.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  sequencer idle; accepts command.
- cmd_rw_i  in  1  1 = read, 0 = write.
- cmd_dev_i  in  7  I2C device address.
- cmd_reg_i  in  8  device register address.
- cmd_wdata_i  in  8  write data (ignored for reads).
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  8  read data (0 for writes and errors).
- rsp_err_o  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout.
- m_cyc_o  out  1  WB cycle to the controller.
- m_stb_o  out  1  WB strobe.
- m_we_o  out  1  WB write enable.
- m_adr_o  out  3  WB address.
- m_dat_o  out  8  WB write data.
- m_dat_i  in  8  WB read data.
- m_ack_i  in  1  WB acknowledge.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is synchronous and active-low on wb_rst_n_i.
- Reset values: all outputs 0 (cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o).
- Reset asserted mid-operation: cyc/stb drop at the next edge, any in-flight command is discarded with no response, and init re-runs after release.
- Controller register map: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR(w)/RXR(r), 4 CR(w)/SR(r).
- CR bits: STA 7, STO 6, RD 5, WR 4, ACK 3.
- SR bits: RxACK 7, BUSY 6, AL 5, TIP 1.
- WB access rules:
  - cyc, stb, we, adr and dat are asserted together and held until the edge where m_ack_i=1.
  - cyc/stb are low for at least one cycle between accesses.
  - ack received while cyc=0 is ignored.
  - No WB timeout; a hung ack stalls the sequencer.
- FSM states: INIT, IDLE, ACCESS, POLL, CHECK, STOP, RESP.
- INIT: WB writes adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], adr2=0x80, then IDLE.
- IDLE:
  - cmd_ready_o=1.
  - Handshake on cmd_valid_i & cmd_ready_o; the command fields are latched that cycle.
  - cmd_ready_o=0 from the following cycle until after RESP.
- Write sequence (TXR value, CR value, then poll):
  - {dev,0}, 0x90
  - reg, 0x10
  - wdata, 0x50
- Read sequence (TXR value, CR value, then poll):
  - {dev,0}, 0x90
  - reg, 0x10
  - {dev,1}, 0x90
  - then CR=0x68 (STO|RD|NACK), poll, then WB read adr3 into rsp_rdata_o.
- POLL:
  - Repeated WB reads of adr4 until SR.TIP=0; the poll counter resets per byte.
  - The TIMEOUT_POLLS-th read with TIP still 1 signals a timeout.
- CHECK (priority order, applied after each byte):
  - AL=1: err 10, go to RESP without STOP (bus lost).
  - Else RxACK=1 on a write/address byte: err 01, go to STOP.
  - Else continue. RxACK is not checked after the final read byte (NACK is intentional).
- Timeout: err 11, go to STOP.
- STOP: WB write CR=0x40, then RESP; no polling after the stop.
- RESP: rsp_valid_o=1 for exactly one cycle with rsp_rdata_o/rsp_err_o valid; IDLE next cycle, so cmd_ready_o rises the cycle after rsp_valid_o.
- cmd_valid_i while not ready is held off; there is no queue.

Decomposition:
- Package i2c_seq_pkg:
  - register address constants;
  - CR command constants (CMD_START_WR=0x90, CMD_WR=0x10, CMD_WR_STOP=0x50, CMD_RD_NACK_STOP=0x68, CMD_STOP=0x40);
  - SR bit indices;
  - 2-bit error enum;
  - FSM state enum.
- One sub-module, i2c_seq_wb_access:
  - single-access WB master engine;
  - inputs: start, we, adr, dat; outputs: done pulse, rdata;
  - enforces the hold-until-ack and idle-gap rules.
- Top level: sequencing FSM, step counter, poll counter.

Test Plan:
- Release reset (PRESCALE=0x0063) -> WB writes adr0=0x63, adr1=0x00, adr2=0x80 in order; then cmd_ready_o=1; all outputs 0 during reset.
- Write dev=0x50 reg=0x10 data=0xA5, model always acks -> TXR 0xA0/0x10/0xA5 and CR 0x90/0x10/0x50, each followed by SR polls; rsp_err_o=00, rsp_rdata_o=0x00.
- Read dev=0x50 reg=0x22, RXR model=0x3C -> TXR 0xA0/0x22/0xA1, CR 0x90/0x10/0x90/0x68, final read adr3; rsp_rdata_o=0x3C, rsp_err_o=00.
- SR.RxACK=1 after address byte -> no further TXR writes; CR=0x40 written; rsp_err_o=01; cmd_ready_o=1 the cycle after rsp_valid_o.
- SR.AL=1 on second byte -> rsp_err_o=10, no CR=0x40 write. TIP stuck at 1 with TIMEOUT_POLLS=8 -> exactly 8 SR reads, then CR=0x40, rsp_err_o=11.
- wb_rst_n_i=0 during a read poll -> m_cyc_o/m_stb_o=0 next cycle, no rsp_valid_o; after release the INIT writes repeat.
